// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared funct3 encodings, responder state type and latency range
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// lsu_load_ext : selects the addressed byte/half of a word and sign/zero extends
// Revision     : 1.0
// ============================================================================
module lsu_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {byte_off, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : fixed-latency load/store responder with byte-lane merging
// Revision       : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr, cap_wdata;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept, commit;
    logic        src_we;
    logic [2:0]  src_f3;
    logic [31:0] src_addr, src_wdata;
    logic        illegal, misaligned, out_of_range, err;
    logic [IDX_W-1:0] idx;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [31:0] rd_word, load_val;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req_valid && (state == IDLE);
    assign commit = (state == WAIT && cnt == 4'd0) || (accept && LAT == 1);

    // With single-cycle latency the commit happens on the accept edge, so the
    // live request is used instead of the not-yet-captured copy.
    assign src_we    = (state == IDLE) ? req_we     : cap_we;
    assign src_f3    = (state == IDLE) ? req_funct3 : cap_f3;
    assign src_addr  = (state == IDLE) ? req_addr   : cap_addr;
    assign src_wdata = (state == IDLE) ? req_wdata  : cap_wdata;
    assign idx       = src_addr[IDX_W+1:2];

    always_comb begin
        if (src_we)
            illegal = !(src_f3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(src_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned   = ((src_f3 == F3_H || src_f3 == F3_HU) && src_addr[0]) ||
                       (src_f3 == F3_W && src_addr[1:0] != 2'b00);
        out_of_range = {2'b00, src_addr[31:2]} >= 32'(DEPTH_WORDS);
        err          = illegal || misaligned || out_of_range;
    end

    always_comb begin
        lane_en   = 4'b0000;
        lane_data = src_wdata;
        case (src_f3)
            F3_B: begin
                lane_en   = 4'b0001 << src_addr[1:0];
                lane_data = {4{src_wdata[7:0]}};
            end
            F3_H: begin
                lane_en   = src_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{src_wdata[15:0]}};
            end
            F3_W:    lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    // Array is deliberately unreset; reset still blocks a pending commit.
    always_ff @(posedge clk) begin
        if (reset && commit && src_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b])
                    mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[idx];

    lsu_load_ext u_load_ext (
        .word     (rd_word),
        .byte_off (src_addr[1:0]),
        .funct3   (src_f3),
        .data     (load_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_f3    <= 3'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_we    <= req_we;
                cap_f3    <= req_funct3;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (commit) begin
                err_q   <= err;
                rdata_q <= (err || src_we) ? 32'd0 : load_val;
            end else if (state == RESP && rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (LAT == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0)
                    state_next = RESP;
                else
                    cnt_next = cnt - 4'd1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : randomized self-checking bench with byte-level memory model
// Revision          : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [0:DEPTH*4-1];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // Byte-addressed reference: access size, legality and extension from the ISA rules.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] erd, output bit eerr);
        int  sz;
        bit  sgn;
        bit  legal;
        sz = 1; sgn = 0; legal = 1;
        if (we) begin
            legal = (f3 <= 3'd2);
            sz    = 1 << f3[1:0];
        end else begin
            case (f3)
                3'd0: begin sz = 1; sgn = 1; end
                3'd1: begin sz = 2; sgn = 1; end
                3'd2: begin sz = 4; sgn = 0; end
                3'd4: begin sz = 1; sgn = 0; end
                3'd5: begin sz = 2; sgn = 0; end
                default: legal = 0;
            endcase
        end
        eerr = !legal || (a % sz != 0) || (a / 4 >= DEPTH);
        erd  = 32'd0;
        if (!eerr) begin
            for (int i = 0; i < sz; i++) begin
                if (we) mb[a + i] = wd[8*i +: 8];
                else    erd = erd | (32'(mb[a + i]) << (8 * i));
            end
            if (!we && sgn && erd[8*sz-1])
                erd = erd | (32'hFFFF_FFFF << (8 * sz));
        end
    endtask

    // Issues one request from a negedge in IDLE, returns response and observed latency.
    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output bit e,
                       output int lat);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        e  = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd, erd; bit e, ee; int lat;
        model(1, 3'd2, 32'h10, 32'hDEADBEEF, erd, ee);
        txn(1, 3'd2, 32'h10, 32'hDEADBEEF, rd, e, lat);
        checks++;
        if (lat !== LAT || e !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL sw_10: lat=%0d err=%b rdata=%h, want %0d 0 0", lat, e, rd, LAT);
        end
        model(0, 3'd2, 32'h10, 32'd0, erd, ee);
        txn(0, 3'd2, 32'h10, 32'd0, rd, e, lat);
        checks++;
        if (lat !== LAT || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_10: lat=%0d err=%b rdata=%h, want %0d 0 deadbeef", lat, e, rd, LAT);
        end
        model(1, 3'd0, 32'h13, 32'h000000AA, erd, ee);
        txn(1, 3'd0, 32'h13, 32'h000000AA, rd, e, lat);
        model(0, 3'd2, 32'h10, 32'd0, erd, ee);
        txn(0, 3'd2, 32'h10, 32'd0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'hAAADBEEF) begin
            errors++;
            $display("FAIL sb_merge: err=%b rdata=%h, want 0 aaadbeef", e, rd);
        end
    endtask

    task automatic test_extend;
        logic [31:0] rd, erd; bit e, ee; int lat;
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8080, 32'h00008080};
        model(1, 3'd2, 32'h20, 32'h00008080, erd, ee);
        txn(1, 3'd2, 32'h20, 32'h00008080, rd, e, lat);
        for (int i = 0; i < 4; i++) begin
            model(0, f3s[i], 32'h20, 32'd0, erd, ee);
            txn(0, f3s[i], 32'h20, 32'd0, rd, e, lat);
            checks++;
            if (e !== 1'b0 || rd !== exp[i]) begin
                errors++;
                $display("FAIL extend_f3_%0d: err=%b rdata=%h, want 0 %h", f3s[i], e, rd, exp[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd, erd; bit e, ee; int lat;
        bit          wes [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
        logic [31:0] ads [4] = '{32'h02, 32'h31, DEPTH * 4, 32'h30};
        model(1, 3'd2, 32'h30, 32'h0BADF00D, erd, ee);
        txn(1, 3'd2, 32'h30, 32'h0BADF00D, rd, e, lat);
        for (int i = 0; i < 4; i++) begin
            model(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, erd, ee);
            txn(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, rd, e, lat);
            checks++;
            if (e !== 1'b1 || rd !== 32'd0 || lat !== LAT) begin
                errors++;
                $display("FAIL fault_%0d: err=%b rdata=%h lat=%0d, want 1 0 %0d", i, e, rd, lat, LAT);
            end
        end
        txn(0, 3'd2, 32'h30, 32'd0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL fault_no_side_effect: err=%b rdata=%h, want 0 0badf00d", e, rd);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] erd; bit ee; int lat;
        model(0, 3'd2, 32'h10, 32'd0, erd, ee);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== erd) begin
            errors++;
            $display("FAIL bp_first: valid=%b rdata=%h, want 1 %h", rsp_valid, rsp_rdata, erd);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== erd || req_ready !== 1'b0 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b err=%b, want 1 %h 0 0",
                         k, rsp_valid, rsp_rdata, req_ready, rsp_err, erd);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd, erd; bit e, ee; int lat; bit seen;
        model(1, 3'd2, 32'h40, 32'd0, erd, ee);
        txn(1, 3'd2, 32'h40, 32'd0, rd, e, lat);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset_state: ready=%b valid=%b rdata=%h, want 1 0 0",
                     req_ready, rsp_valid, rsp_rdata);
        end
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_response: rsp_valid seen=%b, want 0", seen);
        end
        @(negedge clk);
        txn(0, 3'd2, 32'h40, 32'd0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL abort_no_commit: err=%b rdata=%h, want 0 00000000", e, rd);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, a, wd; bit e, ee, we; int lat; logic [2:0] f3;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model(1, 3'd2, 32'h100 + 32'(w * 4), wd, erd, ee);
            txn(1, 3'd2, 32'h100 + 32'(w * 4), wd, rd, e, lat);
        end
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            wd = $urandom;
            if ($urandom % 8 == 0) a = 32'h400 + 32'($urandom % 64);
            else                   a = 32'h100 + 32'($urandom % 256);
            model(we, f3, a, wd, erd, ee);
            txn(we, f3, a, wd, rd, e, lat);
            checks++;
            if (rd !== erd || e !== ee || lat !== LAT) begin
                errors++;
                $display("FAIL random_%0d we=%b f3=%0d addr=%h: rdata=%h err=%b lat=%0d, want %h %b %0d",
                         n, we, f3, a, rd, e, lat, erd, ee, LAT);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        reset = 1'b1;
        test_reset;
        test_store_load;
        test_extend;
        test_errors;
        test_backpressure;
        test_reset_abort;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
